// File: rtl/dcro_freq_meter.sv
// Gated edge counter for the divided DCRO output: counts synchronised osc_in
// rising edges over a programmable window of clk cycles and reports a saturating count.
module dcro_freq_meter #(
  parameter int GATE_W      = 16,
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              osc_in,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic [1:0]        state_dbg
);

  // Handshake: start is a request sampled only while busy=0; while busy=1 it is
  // dropped, not queued. done is a single-cycle strobe and count/overflow are
  // valid from that cycle until the next done.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    GATE = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [GATE_W-1:0] SYNC_LAST = GATE_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_t             state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               hist_q;
  logic               edge_det;
  logic [GATE_W-1:0]  gate_q;
  logic [GATE_W-1:0]  phase_q;
  logic [GATE_W-1:0]  gate_last;
  logic [CNT_W-1:0]   work_q, work_d;
  logic               ovf_q, ovf_d;
  logic               load_result;

  // Synchroniser and edge history run in every state so the SYNC phase only
  // has to flush stale history, never wait for the chain to fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det  = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign gate_last = gate_q - GATE_W'(1);

  always_comb begin
    state_nxt = state;
    work_d    = work_q;
    ovf_d     = ovf_q;
    case (state)
      IDLE: begin
        if (start) state_nxt = SYNC;
      end
      SYNC: begin
        if (phase_q == SYNC_LAST) state_nxt = (gate_q == '0) ? DONE : GATE;
      end
      GATE: begin
        if (edge_det) begin
          if (work_q == CNT_MAX) ovf_d = 1'b1;
          else                   work_d = work_q + CNT_W'(1);
        end
        if (phase_q == gate_last) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Results are registered on entry to DONE so they are already valid while done=1.
  assign load_result = (state_nxt == DONE) && (state != DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      phase_q  <= '0;
      gate_q   <= '0;
      work_q   <= '0;
      ovf_q    <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state  <= state_nxt;
      work_q <= work_d;
      ovf_q  <= ovf_d;
      if ((state_nxt != state) || (state == IDLE)) phase_q <= '0;
      else                                         phase_q <= phase_q + GATE_W'(1);
      if ((state == IDLE) && start) begin
        gate_q <= gate_cycles;
        work_q <= '0;
        ovf_q  <= 1'b0;
      end
      if (load_result) begin
        count    <= work_d;
        overflow <= ovf_d;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_dcro_freq_meter.sv
// Bench for dcro_freq_meter: waveform-level model of gated edge counting for a
// default-width and a 4-bit-count instance driven by the same stimulus.
module tb_dcro_freq_meter;

  localparam int SS     = 2;
  localparam int MAX24  = 24'hFFFFFF;
  localparam int MAX4   = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] gate_cycles;
  logic        osc_in;
  logic        busy, done, overflow;
  logic [23:0] count;
  logic [1:0]  state_dbg;
  logic        busy4, done4, overflow4;
  logic [3:0]  count4;
  logic [1:0]  state_dbg4;

  dcro_freq_meter dut (
    .clk(clk), .rst(rst), .start(start), .gate_cycles(gate_cycles), .osc_in(osc_in),
    .busy(busy), .done(done), .count(count), .overflow(overflow), .state_dbg(state_dbg)
  );

  dcro_freq_meter #(.GATE_W(16), .CNT_W(4), .SYNC_STAGES(SS)) dut4 (
    .clk(clk), .rst(rst), .start(start), .gate_cycles(gate_cycles), .osc_in(osc_in),
    .busy(busy4), .done(done4), .count(count4), .overflow(overflow4), .state_dbg(state_dbg4)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  int osc_mode = 0;   // 0 stuck low, 1 stuck high, 2 clk/2, 4 clk/4
  int vectors = 0;
  int miscompares = 0;
  int fail_prints = 0;

  // ---------------- model ----------------
  bit          osc_h [0:32767];
  bit          pend = 1'b0;
  int          k_m, g_m, d_m;
  logic [23:0] exp_cnt  = '0;
  logic        exp_ovf  = 1'b0;
  logic [3:0]  exp_cnt4 = '0;
  logic        exp_ovf4 = 1'b0;

  // Rising transitions of the recorded waveform that fall inside the window:
  // the synchroniser delays osc_in by SS cycles, so the window opens SS cycles after acceptance.
  function automatic int edges_in_window(input int k, input int g);
    int n = 0;
    for (int j = k + SS; j < k + SS + g; j++)
      if (osc_h[j] && !osc_h[j-1]) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    if (cyc < 32768) osc_h[cyc] = osc_in;
    if (rst) begin
      pend     = 1'b0;
      exp_cnt  = '0;
      exp_ovf  = 1'b0;
      exp_cnt4 = '0;
      exp_ovf4 = 1'b0;
    end else begin
      if (pend && cyc > d_m) pend = 1'b0;
      if (!pend && start) begin
        pend = 1'b1;
        k_m  = cyc;
        g_m  = int'(gate_cycles);
        d_m  = cyc + SS + 2 + g_m;
      end
    end
    cyc++;
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic eb, ed;
    int   e;
    if (cyc >= 1) begin
      if (pend && cyc == d_m) begin
        e        = edges_in_window(k_m, g_m);
        exp_cnt  = (e > MAX24) ? 24'(MAX24) : 24'(e);
        exp_ovf  = (e > MAX24);
        exp_cnt4 = (e > MAX4) ? 4'(MAX4) : 4'(e);
        exp_ovf4 = (e > MAX4);
      end
      eb = pend && (cyc > k_m) && (cyc <= d_m);
      ed = pend && (cyc == d_m);
      vectors++;
      if ({busy, done, overflow, count, busy4, done4, overflow4, count4} !==
          {eb, ed, exp_ovf, exp_cnt, eb, ed, exp_ovf4, exp_cnt4}) begin
        miscompares++;
        if (fail_prints < 20) begin
          fail_prints++;
          $display("FAIL cycle%0d outputs: busy=%b done=%b ovf=%b cnt=%0d busy4=%b done4=%b ovf4=%b cnt4=%0d, expected busy=%b done=%b ovf=%b cnt=%0d ovf4=%b cnt4=%0d",
                   cyc, busy, done, overflow, count, busy4, done4, overflow4, count4,
                   eb, ed, exp_ovf, exp_cnt, exp_ovf4, exp_cnt4);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  initial begin
    osc_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (osc_mode)
        1:       osc_in = 1'b1;
        2:       osc_in = (cyc % 2) == 1;
        4:       osc_in = ((cyc / 2) % 2) == 1;
        default: osc_in = 1'b0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic measure(input string name, input int g, input int lat_e,
                         input int cnt_e, input int ovf_e, input int cnt4_e, input int ovf4_e);
    int k;
    int lat;
    tick();
    start       = 1'b1;
    gate_cycles = 16'(g);
    k           = cyc;
    tick();
    start       = 1'b0;
    gate_cycles = 16'($urandom_range(0, 65535));
    lat = -1;
    for (int i = 0; i < 2000 && lat < 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) lat = cyc - k;
    end
    check_lit({name, " latency"}, lat, lat_e);
    check_lit({name, " count"}, count, cnt_e);
    check_lit({name, " overflow"}, overflow, ovf_e);
    check_lit({name, " count4"}, count4, cnt4_e);
    check_lit({name, " overflow4"}, overflow4, ovf4_e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n_done;
    int k;
    int d [3];
    int nd;
    rst = 1'b1; start = 1'b0; gate_cycles = '0; osc_mode = 0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check_lit("reset busy", busy, 0);
    check_lit("reset done", done, 0);
    check_lit("reset count", count, 0);
    check_lit("reset overflow", overflow, 0);

    osc_mode = 4; idle(6);
    measure("clk4_g100", 100, 104, 25, 0, 15, 1);
    osc_mode = 0; idle(6);
    measure("stuck0_g50", 50, 54, 0, 0, 0, 0);
    osc_mode = 1; idle(6);
    measure("stuck1_g50", 50, 54, 0, 0, 0, 0);
    osc_mode = 2; idle(6);
    measure("clk2_g100", 100, 104, 50, 0, 15, 1);
    osc_mode = 4; idle(6);
    measure("clk4_g20", 20, 24, 5, 0, 5, 0);

    // Reset in the middle of the gate window aborts without a done pulse.
    tick();
    start = 1'b1; gate_cycles = 16'd50;
    tick();
    start = 1'b0;
    idle(20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_lit("midrst busy", busy, 0);
    check_lit("midrst done", done, 0);
    check_lit("midrst count", count, 0);
    check_lit("midrst overflow", overflow, 0);
    n_done = 0;
    repeat (80) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    check_lit("midrst no done", n_done, 0);
    measure("after_rst_clk4_g100", 100, 104, 25, 0, 15, 1);

    // A start pulse during GATE must not queue a second measurement.
    tick();
    start = 1'b1; gate_cycles = 16'd100;
    tick();
    start = 1'b0;
    idle(30);
    start = 1'b1;
    tick();
    start = 1'b0;
    n_done = 0;
    repeat (150) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    check_lit("ignored start done pulses", n_done, 1);

    // start held high: back-to-back runs spaced by one IDLE cycle.
    tick();
    start = 1'b1; gate_cycles = 16'd10;
    k = cyc;
    nd = 0;
    for (int i = 0; i < 200 && nd < 3; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        d[nd] = cyc;
        nd++;
      end
    end
    tick();
    start = 1'b0;
    check_lit("b2b done count", nd, 3);
    check_lit("b2b first latency", d[0] - k, 14);
    check_lit("b2b spacing 1", d[1] - d[0], 15);
    check_lit("b2b spacing 2", d[2] - d[1], 15);
    idle(20);

    measure("gate0", 0, 4, 0, 0, 0, 0);
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
